// File: rtl/mem_access_controller_if.sv
// Pipeline-side request/response bundle for the data memory sequencer.
// The master is the MEM stage and the slave is the controller.
interface mem_access_controller_if;
    logic        req_valid;
    logic        req_ready;
    logic        mem_read;
    logic        mem_write;
    logic [1:0]  load_mode;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        done;
    logic        error;
    logic        stall;

    modport master (
        output req_valid, mem_read, mem_write,
        output load_mode, address, write_data,
        input  req_ready, read_data, done, error, stall
    );

    modport slave (
        input  req_valid, mem_read, mem_write,
        input  load_mode, address, write_data,
        output req_ready, read_data, done, error, stall
    );
endinterface

// File: rtl/mem_access_controller.sv
// Byte-serial load/store sequencer between the MEM stage and a byte RAM.
// Big-endian byte order; illegal requests complete with error and no access.
module mem_access_controller #(
    parameter int unsigned MEM_BYTES = 4000
) (
    input  logic                     clk,
    input  logic                     rst_n,
    mem_access_controller_if.slave   bus,
    output logic [31:0]              ram_addr_o,
    output logic                     ram_we_o,
    output logic [7:0]               ram_wdata_o,
    input  logic [7:0]               ram_rdata_i
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_DONE   = 2'd2;

    localparam logic [32:0] LAST_ADDR = 33'(MEM_BYTES - 1);

    logic [1:0]  state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [1:0]  mode_q, mode_d;
    logic        load_q, load_d;
    logic [23:0] acc_q, acc_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic        accept;
    logic        req_word;
    logic [32:0] req_end;
    logic        req_bad;
    logic        req_nop;
    logic [1:0]  last_cnt;
    logic [7:0]  store_byte;
    logic [31:0] full;

    assign accept   = bus.req_valid && (state_q == S_IDLE);
    assign req_word = !bus.mem_read || (bus.load_mode == 2'b00);
    // 33-bit sum so an address near 2^32 cannot wrap into range
    assign req_end  = {1'b0, bus.address}
                    + (req_word ? 33'd3 : 33'd1);
    assign req_nop  = !bus.mem_read && !bus.mem_write;
    assign req_bad  = (bus.mem_read && bus.mem_write)
                   || (bus.mem_read && bus.load_mode == 2'b11)
                   || (!req_nop && req_end > LAST_ADDR);

    assign last_cnt = (load_q && mode_q != 2'b00) ? 2'd1 : 2'd3;
    assign full     = {acc_q, ram_rdata_i};

    // Select the store byte, MSB first
    always_comb begin
        store_byte = wdata_q[7:0];
        unique case (cnt_q)
            2'd0:    store_byte = wdata_q[31:24];
            2'd1:    store_byte = wdata_q[23:16];
            2'd2:    store_byte = wdata_q[15:8];
            default: store_byte = wdata_q[7:0];
        endcase
    end

    // Sequencer next state, datapath and RAM drive
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        mode_d      = mode_q;
        load_d      = load_q;
        acc_d       = acc_q;
        rdata_d     = rdata_q;
        err_d       = err_q;
        ram_addr_o  = 32'd0;
        ram_we_o    = 1'b0;
        ram_wdata_o = 8'd0;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    addr_d  = bus.address;
                    wdata_d = bus.write_data;
                    mode_d  = bus.load_mode;
                    load_d  = bus.mem_read;
                    cnt_d   = 2'd0;
                    acc_d   = 24'd0;
                    if (req_bad) begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end else if (req_nop) begin
                        err_d   = 1'b0;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_ACCESS;
                    end
                end
            end
            S_ACCESS: begin
                ram_addr_o = addr_q + 32'(cnt_q);
                if (!load_q) begin
                    ram_we_o    = 1'b1;
                    ram_wdata_o = store_byte;
                end
                acc_d = full[23:0];
                cnt_d = cnt_q + 2'd1;
                if (cnt_q == last_cnt) begin
                    err_d   = 1'b0;
                    state_d = S_DONE;
                    if (load_q) begin
                        unique case (mode_q)
                            2'b00: rdata_d = full;
                            2'b01: rdata_d = {{16{full[15]}},
                                              full[15:0]};
                            default: rdata_d = {16'h0, full[15:0]};
                        endcase
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= 2'd0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            mode_q  <= 2'd0;
            load_q  <= 1'b0;
            acc_q   <= 24'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            mode_q  <= mode_d;
            load_q  <= load_d;
            acc_q   <= acc_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign bus.req_ready = (state_q == S_IDLE);
    assign bus.done      = (state_q == S_DONE);
    assign bus.stall     = (state_q != S_IDLE);
    assign bus.read_data = rdata_q;
    assign bus.error     = err_q;

endmodule
